// File: rtl/prime_stream_pkg.sv
// Shared types and constants for the prime_stream sequencer and its FIFO.
package prime_stream_pkg;

    localparam int unsigned PS_WIDTH_LOG = 4;
    localparam int unsigned PS_DEPTH_LOG = 2;

    typedef enum logic [1:0] {
        PS_IDLE = 2'd0,
        PS_REQ  = 2'd1,
        PS_WAIT = 2'd2,
        PS_HALT = 2'd3
    } ps_state_e;

    // Prime width derived from its log2.
    function automatic int unsigned ps_width(input int unsigned width_log);
        return 32'd1 << width_log;
    endfunction

endpackage

// File: rtl/prime_stream_if.sv
// Valid/ready stream carrying primes to the consumer.
interface prime_stream_if #(
    parameter int unsigned WIDTH = 16
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/prime_stream_fifo.sv
// Small FIFO with a registered head read; count kept separately from pointers.
module prime_fifo #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [WIDTH-1:0]     din_i,
    input  logic                 pop_i,
    output logic [WIDTH-1:0]     dout_o,
    output logic [DEPTH_LOG:0]   count_o,
    output logic                 empty_o,
    output logic                 full_o
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic [WIDTH-1:0]     dout_q, dout_d;

    // Next head: bypass the incoming word when it lands on the new read slot.
    always_comb begin
        rd_ptr_d = rd_ptr_q + DEPTH_LOG'(pop_i);
        count_d  = count_q + (DEPTH_LOG+1)'(push_i) - (DEPTH_LOG+1)'(pop_i);
        dout_d   = (push_i && (wr_ptr_q == rd_ptr_d)) ? din_i : mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(push_i);
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = dout_q;
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (DEPTH_LOG+1)'(DEPTH));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(push_i && full_o));
            assert (!(pop_i && empty_o));
        end
    end

endmodule

// File: rtl/prime_stream.sv
// Sequences requests to the prime generator, buffers results, and latches
// a sticky overflow when the generator reports an error.
module prime_stream
    import prime_stream_pkg::*;
#(
    parameter int unsigned WIDTH_LOG = PS_WIDTH_LOG,
    parameter int unsigned DEPTH_LOG = PS_DEPTH_LOG
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable_i,
    output logic                          gen_go_o,
    input  logic                          gen_ready_i,
    input  logic                          gen_error_i,
    input  logic [(1 << WIDTH_LOG)-1:0]   gen_res_i,
    prime_stream_if.master                out_if,
    output logic [DEPTH_LOG:0]            count_o,
    output logic                          overflow_o
);
    localparam int unsigned WIDTH = ps_width(WIDTH_LOG);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG;

    ps_state_e            state_q, state_d;
    logic                 gen_go_q, gen_go_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop, inflight, room;
    logic                 fifo_empty, fifo_full;
    logic [DEPTH_LOG:0]   count;
    logic [WIDTH-1:0]     fifo_dout;

    assign pop      = out_if.ready && !fifo_empty;
    assign inflight = (state_q == PS_REQ) || (state_q == PS_WAIT);
    // Room counts the slot reserved by an outstanding request.
    assign room     = !fifo_full && !(inflight && (count == (DEPTH_LOG+1)'(DEPTH - 1)));

    always_comb begin
        state_d    = state_q;
        overflow_d = overflow_q;
        push       = 1'b0;
        case (state_q)
            PS_IDLE: begin
                if (enable_i && !overflow_q && gen_ready_i && room) state_d = PS_REQ;
            end
            PS_REQ:  state_d = PS_WAIT;
            PS_WAIT: begin
                if (gen_ready_i) begin
                    if (gen_error_i) begin
                        overflow_d = 1'b1;
                        state_d    = PS_HALT;
                    end else begin
                        push    = 1'b1;
                        state_d = PS_IDLE;
                    end
                end
            end
            PS_HALT: state_d = PS_HALT;
            default: state_d = PS_IDLE;
        endcase
        gen_go_d = (state_d == PS_REQ);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= PS_IDLE;
            gen_go_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            gen_go_q   <= gen_go_d;
            overflow_q <= overflow_d;
        end
    end

    prime_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH_LOG (DEPTH_LOG)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .din_i   (gen_res_i),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .count_o (count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign gen_go_o     = gen_go_q;
    assign overflow_o   = overflow_q;
    assign count_o      = count;
    assign out_if.valid = !fifo_empty;
    assign out_if.data  = fifo_dout;

    always_ff @(posedge clk) begin
        assert (!$isunknown({clk, rst_n}));
        if (rst_n && push) assert (gen_res_i[0] || (gen_res_i == WIDTH'(2)));
    end

endmodule

// File: tb/tb_prime_stream.sv
// Scoreboard bench for prime_stream against a behavioural prime generator.
module tb_prime_stream;
    import prime_stream_pkg::*;

    localparam int unsigned WIDTH   = 16;
    localparam int          GEN_LAT = 3;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        gen_go, gen_ready, gen_error;
    logic [15:0] gen_res;
    logic [2:0]  count;
    logic        overflow;

    prime_stream_if #(.WIDTH(WIDTH)) out_if ();

    prime_stream #(.WIDTH_LOG(4), .DEPTH_LOG(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable_i    (enable),
        .gen_go_o    (gen_go),
        .gen_ready_i (gen_ready),
        .gen_error_i (gen_error),
        .gen_res_i   (gen_res),
        .out_if      (out_if),
        .count_o     (count),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    // Behavioural generator: ready drops after go, result after GEN_LAT cycles.
    int   primes [16] = '{2, 3, 5, 7, 11, 13, 17, 19, 23, 29, 31, 37, 41, 43, 47, 53};
    int   err_at = 0;
    int   req_cnt, gen_idx, lat;
    logic busy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_ready <= 1'b1;
            gen_error <= 1'b0;
            gen_res   <= 16'd1;
            busy      <= 1'b0;
            lat       <= 0;
            req_cnt   <= 0;
            gen_idx   <= 0;
        end else if (gen_go) begin
            gen_ready <= 1'b0;
            busy      <= 1'b1;
            lat       <= GEN_LAT - 1;
            req_cnt   <= req_cnt + 1;
        end else if (busy) begin
            if (lat == 0) begin
                busy      <= 1'b0;
                gen_ready <= 1'b1;
                if (req_cnt == err_at) gen_error <= 1'b1;
                else begin
                    gen_res <= 16'(primes[gen_idx]);
                    gen_idx <= gen_idx + 1;
                end
            end else begin
                lat <= lat - 1;
            end
        end
    end

    int   exp_q [$];
    chk_t chk_q [$];
    int   checks = 0;
    int   errors = 0;
    int   go_cnt = 0;
    logic prev_go = 1'b0;

    // Monitor: owns all comparisons and both counters.
    always @(negedge clk) begin : monitor
        int   e;
        chk_t c;
        while (chk_q.size() != 0) begin
            c = chk_q.pop_front();
            checks++;
            if (c.act != c.exp) begin
                errors++;
                $display("FAIL %s: got %0d, expected %0d", c.name, c.act, c.exp);
            end
        end
        if (rst_n) begin
            if (gen_go) begin
                checks++;
                go_cnt++;
                if (prev_go || !gen_ready) begin
                    errors++;
                    $display("FAIL gen_go_pulse: prev_go=%0b gen_ready=%0b, expected 0 and 1",
                             prev_go, gen_ready);
                end
            end
            if (out_if.valid && out_if.ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_data: got %0d, expected no output", out_if.data);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(out_if.data) != e) begin
                        errors++;
                        $display("FAIL out_data: got %0d, expected %0d", out_if.data, e);
                    end
                end
            end
        end
        prev_go = gen_go;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic do_reset();
        out_if.ready = 1'b0;
        enable       = 1'b0;
        rst_n        = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_drain_left"}, exp_q.size(), 0);
        out_if.ready = 1'b0;
    endtask

    task automatic wait_count(input string name, input int target, input int budget);
        int n = 0;
        while (int'(count) != target && n < budget) begin
            step();
            n++;
        end
        chk({name, "_count_reached"}, int'(count), target);
    endtask

    initial begin : stim
        int   go_base;
        int   n;
        logic rise, pulsed_prev, prev_rdy;
        out_if.ready = 1'b0;

        // Reset state
        step();
        step();
        chk("reset_count", int'(count), 0);
        chk("reset_valid", int'(out_if.valid), 0);
        chk("reset_data", int'(out_if.data), 0);
        chk("reset_overflow", int'(overflow), 0);
        chk("reset_go", int'(gen_go), 0);
        rst_n = 1'b1;
        step();

        // Free run: 1 never emitted
        foreach (primes[i]) if (i < 9) exp_q.push_back(primes[i]);
        enable = 1'b1;
        out_if.ready = 1'b1;
        wait_drain("run", 200);
        enable = 1'b0;

        // Backpressure
        do_reset();
        go_base = go_cnt;
        enable = 1'b1;
        repeat (60) step();
        chk("bp_count_full", int'(count), 4);
        chk("bp_go_total", go_cnt - go_base, 4);
        chk("bp_head", int'(out_if.data), 2);
        exp_q.push_back(2);
        out_if.ready = 1'b1;
        step();
        out_if.ready = 1'b0;
        chk("bp_count_after_pop", int'(count), 3);
        repeat (30) step();
        chk("bp_count_refill", int'(count), 4);
        chk("bp_go_refill", go_cnt - go_base, 5);
        chk("bp_head_after_pop", int'(out_if.data), 3);
        exp_q.push_back(3); exp_q.push_back(5); exp_q.push_back(7); exp_q.push_back(11);
        out_if.ready = 1'b1;
        wait_drain("bp", 20);
        enable = 1'b0;

        // Overflow on 3rd request
        err_at = 3;
        do_reset();
        go_base = go_cnt;
        enable = 1'b1;
        repeat (50) step();
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_count", int'(count), 2);
        chk("ovf_go", go_cnt - go_base, 3);
        repeat (20) step();
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_go_after", go_cnt - go_base, 3);
        exp_q.push_back(2); exp_q.push_back(3);
        out_if.ready = 1'b1;
        wait_drain("ovf", 20);
        chk("ovf_drained_count", int'(count), 0);
        chk("ovf_after_drain", int'(overflow), 1);
        enable = 1'b0;
        err_at = 0;

        // Push coinciding with pop at count=2, 10 primes through depth 4
        do_reset();
        go_base = go_cnt;
        foreach (primes[i]) if (i < 10) exp_q.push_back(primes[i]);
        enable = 1'b1;
        wait_count("pp", 2, 100);
        prev_rdy = gen_ready;
        pulsed_prev = 1'b0;
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (pulsed_prev) chk("pp_count_steady", int'(count), 2);
            if (!enable && exp_q.size() == 2) break;
            if (go_cnt - go_base >= 10) enable = 1'b0;
            rise = gen_ready && !prev_rdy;
            out_if.ready = rise;
            pulsed_prev = rise;
            prev_rdy = gen_ready;
        end
        chk("pp_loop_done", exp_q.size(), 2);
        out_if.ready = 1'b1;
        wait_drain("pp", 20);
        chk("pp_final_count", int'(count), 0);
        chk("pp_go_total", go_cnt - go_base, 10);

        // Enable dropped during WAIT
        do_reset();
        go_base = go_cnt;
        exp_q.push_back(2);
        enable = 1'b1;
        out_if.ready = 1'b1;
        n = 0;
        while (go_cnt - go_base < 1 && n < 20) begin
            step();
            n++;
        end
        enable = 1'b0;
        repeat (20) step();
        chk("ed_go", go_cnt - go_base, 1);
        chk("ed_pending", exp_q.size(), 0);
        chk("ed_count", int'(count), 0);
        exp_q.push_back(3);
        enable = 1'b1;
        wait_drain("ed", 40);
        enable = 1'b0;

        // Reset while a request is outstanding
        do_reset();
        enable = 1'b1;
        wait_count("rmw", 3, 100);
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmw_count", int'(count), 0);
        chk("rmw_valid", int'(out_if.valid), 0);
        chk("rmw_overflow", int'(overflow), 0);
        chk("rmw_go", int'(gen_go), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        exp_q.push_back(2);
        out_if.ready = 1'b1;
        wait_drain("rmw", 40);
        enable = 1'b0;

        @(negedge clk);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/prime_stream.md
Name: prime_stream

Overview:
- Downstream sequencer for the prime generator.
- Drives the generator's go input, waits for each result, and buffers results in a small FIFO.
- Presents primes to the rest of the design on a valid/ready stream.
- Latches the generator's error (overflow) as a sticky terminal flag.

Parameters:
- WIDTH_LOG, 4, log2 of prime width. Must match the generator instance.
- DEPTH_LOG, 2, log2 of FIFO depth (DEPTH = 1 << DEPTH_LOG entries).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset. Also reset the generator in the same cycle.
- enable  in  1  level; when high, keep requesting primes while there is room.
- gen_go  out  1  one-cycle request pulse to the generator.
- gen_ready  in  1  generator ready (registered in the generator).
- gen_error  in  1  generator error; valid when gen_ready=1.
- gen_res  in  WIDTH  generator result; valid when gen_ready=1.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head entry.
- out_data  out  WIDTH  FIFO head.
- count  out  DEPTH_LOG+1  FIFO occupancy.
- overflow  out  1  sticky; the generator reported an error.

Behaviour:
- Reset (async assert, sync release): state=IDLE, gen_go=0, out_valid=0, out_data=0, count=0, overflow=0. FIFO pointers are 0.
- The generator's post-reset value (1) is never pushed. The first pushed prime is 2.
- FSM states: IDLE, REQ, WAIT, HALT.
- IDLE -> REQ when enable=1, overflow=0, gen_ready=1, and count + pushes-in-flight < DEPTH. In-flight is always 0 in IDLE, so the check reduces to count < DEPTH with no pop credit taken.
- REQ: gen_go=1 for exactly this cycle, then go to WAIT.
- WAIT: gen_go=0. gen_ready is low from the cycle after REQ.
  - When gen_ready=1 and gen_error=0: push gen_res, go to IDLE.
  - When gen_ready=1 and gen_error=1: set overflow, push nothing, go to HALT.
- HALT: terminal. gen_go stays 0. The FIFO still drains. Only reset leaves HALT.
- Throughput: one prime per (generator latency + 2) cycles minimum. IDLE→REQ→WAIT with capture in WAIT, then back to IDLE.
- gen_go is registered, glitch-free, and never high in two consecutive cycles.
- Room is reserved at REQ, so a push never finds the FIFO full. A push to a full FIFO is an assertion failure in simulation.
- Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged; legal at count=DEPTH only for a pop-only cycle, at count=0 push-only.
- out_data is a registered read of the head. Data pushed into an empty FIFO appears on out_data/out_valid the next cycle.
- Pointers are DEPTH_LOG bits and wrap modulo DEPTH. count is derived separately, never from the pointers alone.
- enable dropping in REQ or WAIT does not abort: the in-flight prime is still captured, then the FSM stays in IDLE.
- Reset mid-WAIT discards the in-flight result. The FIFO empties immediately (async).
- Simulation: assert no X on rst/clk. Assert gen_res is odd or 2 when captured.

Decomposition:
- Shared package holds:
  - FSM state constants (2-bit).
  - PS_IDLE/PS_REQ/PS_WAIT/PS_HALT localparams.
  - the width helpers WIDTH = 1 << WIDTH_LOG.
- One sub-module, prime_fifo:
  - parameters WIDTH and DEPTH_LOG.
  - ports push, din, pop, dout, count, empty/full.
  - same async active-low reset.
- prime_stream owns the FSM, request accounting and the overflow flag.

Test Plan:
- Run, real generator WIDTH_LOG=4: enable=1, out_ready=1 -> out_data sequence 2,3,5,7,11,13,17,19,23. The value 1 is never emitted. gen_go pulses are single-cycle.
- Backpressure: enable=1, out_ready=0 -> exactly 4 pushes (2,3,5,7), count=4, and gen_go stays 0 thereafter. Then set out_ready=1 for one cycle -> pop 2, count=3, one new request, 11 captured later.
- Overflow: mock generator returns gen_ready=1, gen_error=1 on the 3rd request -> overflow=1 and remains set. No further gen_go. The FIFO still drains the two buffered primes.
- Simultaneous push/pop: count=2, capture coincides with pop -> count stays 2 and FIFO order is preserved across pointer wrap (run 10 primes through depth 4).
- Enable drop: deassert enable in the WAIT cycle -> the pending prime is still pushed. No gen_go afterwards until enable returns.
- Reset mid-WAIT: assert rst with 3 entries buffered -> count=0, out_valid=0, overflow=0 asynchronously. After release with enable=1, the first output is 2 again.
